mem_bus_initiator: RTL and testbench

//  Bus master for the native memory interface (mem_valid/mem_ready/mem_addr/mem_rdata/mem_wdata/mem_wstrb).

---
 rtl/mem_bus_initiator_pkg.sv | 18 +
 rtl/mem_bus_initiator_if.sv | 32 +++
 rtl/mem_bus_initiator_timeout.sv | 46 ++++
 rtl/mem_bus_initiator.sv | 88 ++++++++
 tb/tb_mem_bus_initiator.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// Shared types and constants for the native memory-bus initiator and its responders.
package mem_bus_initiator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [3:0]  MemWstrbRead = 4'b0000;
  localparam logic [15:0] IoBase       = 16'h0200;

  // A zero-cycle timeout still needs a 1-bit counter to keep declarations legal.
  function automatic int unsigned timer_width(int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Command stream, response stream and native memory bus seen by the initiator.
interface mem_bus_initiator_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, mem_ready, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, mem_ready, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_bus_initiator_timeout.sv
// Saturating bus-cycle timer; expired flags the last permitted cycle of a stalled request.
module mem_bus_initiator_timeout
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int unsigned W = timer_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] Limit     = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LastCycle = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable && (count_q != Limit)) begin
        count_d = count_q + W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    // count_q holds the number of bus cycles already completed before this one.
    assign expired = enable && (count_q >= LastCycle);
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding bus master: turns a cmd stream into native memory-bus cycles and responses.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  mem_bus_initiator_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q;
  logic        cmd_fire, misaligned, in_bus, timed_out;

  assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
  assign misaligned = ALIGN_CHECK && (bus.cmd_addr[1:0] != 2'b00);
  assign in_bus     = (state_q == StBus);

  mem_bus_initiator_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cmd_fire),
    .enable (in_bus),
    .expired(timed_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_fire) state_d = misaligned ? StResp : StBus;
      StBus:  if (bus.mem_ready || timed_out) state_d = StResp;
      StResp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == StIdle) && rst;
    bus.mem_valid = in_bus;
    bus.rsp_valid = (state_q == StResp);
  end

  // mem_ready takes priority over a timeout landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (cmd_fire) begin
      addr_q  <= bus.cmd_addr;
      wdata_q <= bus.cmd_wdata;
      wstrb_q <= bus.cmd_wstrb;
      rdata_q <= '0;
      err_q   <= misaligned;
    end else if (in_bus) begin
      if (bus.mem_ready) begin
        rdata_q <= (wstrb_q == MemWstrbRead) ? bus.mem_rdata : '0;
        err_q   <= 1'b0;
      end else if (timed_out) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench: vector table plus hand sequences, registered LED/RAM responder, response scoreboard.
module tb_mem_bus_initiator;
  import mem_bus_initiator_pkg::*;

  localparam int unsigned Timeout = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_initiator_if bus ();

  mem_bus_initiator #(
    .TIMEOUT_CYCLES(Timeout),
    .ALIGN_CHECK   (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Registered responder: word 0 at the IO base is the LED register.
  logic        rdy_r;
  logic [31:0] rd_r;
  int          wcnt;
  bit          ram_init;
  logic [31:0] ram [16];
  bit          resp_en;
  int          wait_states;
  bit          inject;

  assign bus.mem_ready = rdy_r | inject;
  assign bus.mem_rdata = rd_r;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_r <= 1'b0;
      rd_r  <= 32'hDEAD_BEEF;
      wcnt  <= 0;
      if (!ram_init) begin
        for (int i = 0; i < 16; i++) ram[i] <= '0;
        ram_init <= 1'b1;
      end
    end else if (bus.mem_valid && !rdy_r && resp_en) begin
      if (wcnt == wait_states) begin
        rdy_r <= 1'b1;
        wcnt  <= 0;
        if (bus.mem_wstrb == MemWstrbRead) begin
          rd_r <= ram[bus.mem_addr[5:2]];
        end else begin
          rd_r <= 32'hDEAD_BEEF;
          for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) ram[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      rdy_r <= 1'b0;
      rd_r  <= 32'hDEAD_BEEF;
      if (!bus.mem_valid) wcnt <= 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mv;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t        vecs [9];
  rsp_t        sb [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          mv_total = 0;
  logic        prev_mv = 1'b0;
  logic        prev_mr = 1'b0;
  logic [67:0] prev_bus = '0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every clock advance goes through here so bus-protocol checks see each cycle.
  task automatic tick();
    @(negedge clk);
    if (prev_mv && prev_mr) check("mv_drop_after_ready", bus.mem_valid, 0);
    else if (prev_mv && bus.mem_valid)
      check("bus_stable", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, prev_bus);
    if (bus.mem_valid) mv_total++;
    prev_mv  = bus.mem_valid;
    prev_mr  = bus.mem_ready;
    prev_bus = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input bit push, input logic [31:0] exp_rdata, input logic exp_err,
                          output int mv0);
    int guard;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    mv0 = mv_total;
    if (!bus.cmd_ready) begin
      check("cmd_accept_wait", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (push) sb.push_back('{exp_rdata, exp_err});
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("rsp_arrives", bus.rsp_valid, 1);
  endtask

  task automatic take_rsp(input string name);
    rsp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_entry"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_rdata"}, bus.rsp_rdata, e.rdata);
      check({name, "_err"}, bus.rsp_err, e.err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, bus.rsp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, mv0;
    vecs[0] = '{32'h0200_0000, 32'h0000_00A5, 4'hF, 0, 32'h0,         1'b0, 3, 2};
    vecs[1] = '{32'h0200_0000, 32'h0,         4'h0, 0, 32'h0000_00A5, 1'b0, 3, 2};
    vecs[2] = '{32'h0200_0004, 32'h1122_3344, 4'h3, 2, 32'h0,         1'b0, 5, 4};
    vecs[3] = '{32'h0200_0004, 32'h0,         4'h0, 1, 32'h0000_3344, 1'b0, 4, 3};
    vecs[4] = '{32'h0200_0004, 32'hAABB_CCDD, 4'hC, 0, 32'h0,         1'b0, 3, 2};
    vecs[5] = '{32'h0200_0004, 32'h0,         4'h0, 3, 32'hAABB_3344, 1'b0, 6, 5};
    vecs[6] = '{32'h0200_0002, 32'h0,         4'h0, 0, 32'h0,         1'b1, 1, 0};
    vecs[7] = '{32'h0200_0001, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1, 1, 0};
    vecs[8] = '{32'h0200_0000, 32'h0,         4'h0, 0, 32'h0000_00A5, 1'b0, 3, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0;
    resp_en = 1'b1;
    wait_states = 0;
    inject = 1'b0;

    repeat (2) tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_bus", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 0);
    rst = 1'b1;
    tick();
    check("idle_cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      wait_states = vecs[i].waits;
      send_cmd(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b1,
               vecs[i].exp_rdata, vecs[i].exp_err, mv0);
      wait_rsp(lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_mv_cycles", i), mv_total - mv0, vecs[i].exp_mv);
      take_rsp($sformatf("vec%0d", i));
      if (i == 0) check("led_value", ram[0], 32'h0000_00A5);
    end
    wait_states = 0;

    // Timeout: responder silent, then a late stray mem_ready while the error response waits.
    resp_en = 1'b0;
    send_cmd({IoBase, 16'h0008}, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, mv0);
    wait_rsp(lat);
    check("timeout_latency", lat, Timeout + 1);
    check("timeout_mv_cycles", mv_total - mv0, Timeout);
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    check("late_ready_rsp_valid", bus.rsp_valid, 1);
    check("late_ready_err", bus.rsp_err, 1);
    check("late_ready_rdata", bus.rsp_rdata, 0);
    check("late_ready_mem_valid", bus.mem_valid, 0);
    take_rsp("timeout");
    resp_en = 1'b1;

    // Backpressure with a competing command held on the cmd stream.
    send_cmd({IoBase, 16'h0004}, 32'h0, 4'h0, 1'b1, 32'hAABB_3344, 1'b0, mv0);
    wait_rsp(lat);
    bus.cmd_addr  = {IoBase, 16'h000C};
    bus.cmd_wdata = 32'h5A5A_5A5A;
    bus.cmd_wstrb = 4'hF;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'hAABB_3344);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_mem_valid", bus.mem_valid, 0);
    end
    take_rsp("backpressure");
    check("no_accept_on_handshake", bus.mem_valid, 0);
    send_cmd({IoBase, 16'h000C}, 32'h5A5A_5A5A, 4'hF, 1'b1, 32'h0, 1'b0, mv0);
    wait_rsp(lat);
    take_rsp("queued_write");
    send_cmd({IoBase, 16'h000C}, 32'h0, 4'h0, 1'b1, 32'h5A5A_5A5A, 1'b0, mv0);
    wait_rsp(lat);
    take_rsp("queued_readback");

    // Reset while the bus request is outstanding: no response may appear.
    resp_en = 1'b0;
    send_cmd({IoBase, 16'h0000}, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, mv0);
    tick();
    check("pre_reset_mem_valid", bus.mem_valid, 1);
    rst = 1'b0;
    #1;
    check("async_rst_mem_valid", bus.mem_valid, 0);
    check("async_rst_rsp_valid", bus.rsp_valid, 0);
    check("async_rst_cmd_ready", bus.cmd_ready, 0);
    check("async_rst_mem_addr", bus.mem_addr, 0);
    tick();
    rst = 1'b1;
    resp_en = 1'b1;
    tick();
    check("post_reset_rsp_valid", bus.rsp_valid, 0);
    send_cmd({IoBase, 16'h0000}, 32'h0, 4'h0, 1'b1, 32'h0000_00A5, 1'b0, mv0);
    wait_rsp(lat);
    check("post_reset_latency", lat, 3);
    take_rsp("post_reset_read");

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
